// File: rtl/ascii_tx_pkg.sv
// ascii_tx_pkg: FSM states, ASCII constants and nibble-to-ASCII helper for ascii_result_tx
package ascii_tx_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, WAIT} state_t;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_X = 8'h78;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic upper);
    return nib < 4'd10 ? ASC_0 + {4'h0, nib} : (upper ? ASC_UA : ASC_LA) + {4'h0, nib} - 8'd10;
  endfunction
endpackage

// File: rtl/lead_zero_cnt.sv
// lead_zero_cnt: data in (NIB nibbles); idx out = leading zero nibble count from MSB, zero out = all nibbles zero
module lead_zero_cnt #(
  parameter int NIB = 8
) (
  input  logic [4*NIB-1:0]       data,
  output logic [$clog2(NIB)-1:0] idx,
  output logic                   zero
);
  localparam int IW = $clog2(NIB);
  always_comb begin
    idx = '0;
    zero = 1'b1;
    for (int i = 0; i < NIB; i++)
      if (data[4*i +: 4] != 4'h0) begin
        idx = IW'(NIB - 1 - i);
        zero = 1'b0;
      end
  end
endmodule

// File: rtl/ascii_result_tx.sv
// ascii_result_tx: hex-to-ASCII result transmitter; alu_done/result in, uart_out/uart_valid out paced by tx_done, busy/done/drop status out
module ascii_result_tx
  import ascii_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int UPPER = 0,
  parameter int SUPPRESS_ZEROS = 1,
  parameter int PREFIX_EN = 0,
  parameter int TERM_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] result,
  input  logic              tx_done,
  output logic [7:0]        uart_out,
  output logic              uart_valid,
  output logic              busy,
  output logic              done,
  output logic              drop
);
  localparam int NIB = DATA_W / 4;
  localparam int CW = $clog2(NIB + 5);
  localparam int IW = $clog2(NIB);
  localparam logic [CW-1:0] TRM = CW'(TERM_EN != 0 ? 2 : 0);
  localparam logic [CW-1:0] PRE = CW'(PREFIX_EN != 0 ? 2 : 0);
  state_t state, nxt;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt, dig, dig_n;
  logic [IW-1:0] lz;
  logic zero, fin, is_pre, is_trm;
  logic [7:0] chr;
  lead_zero_cnt #(.NIB(NIB)) u_lzc (
    .data(sh),
    .idx(lz),
    .zero(zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (alu_done ? SCAN : IDLE) :
          state == SCAN ? EMIT :
          state == EMIT ? WAIT :
          !tx_done ? WAIT :
          cnt == '0 ? IDLE : EMIT;
  always_comb begin
    dig_n = SUPPRESS_ZEROS == 0 ? CW'(NIB) : zero ? CW'(1) : CW'(NIB) - CW'(lz);
    is_pre = cnt > dig + TRM;
    is_trm = cnt <= TRM;
    chr = is_pre ? (cnt == dig + TRM + PRE ? ASC_0 : ASC_X) :
          is_trm ? (cnt == CW'(2) ? ASC_CR : ASC_LF) :
          nib2ascii(sh[DATA_W-1 -: 4], UPPER != 0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      dig <= '0;
      fin <= 1'b0;
      uart_out <= '0;
      uart_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      busy <= state != IDLE;
      uart_valid <= state == EMIT;
      fin <= state == WAIT && tx_done && cnt == '0;
      done <= fin;
      drop <= alu_done && state != IDLE;
      if (state == IDLE && alu_done) sh <= result;
      if (state == SCAN) begin
        sh <= SUPPRESS_ZEROS != 0 ? sh << {lz, 2'b00} : sh;
        dig <= dig_n;
        cnt <= dig_n + TRM + PRE;
      end
      if (state == EMIT) begin
        uart_out <= chr;
        cnt <= cnt - CW'(1);
        if (!is_pre && !is_trm) sh <= sh << 4;
      end
    end
endmodule
